store_unit: RTL



---
 rtl/store_unit_pkg.sv | 21 ++
 rtl/store_unit_merge.sv | 35 +++
 rtl/store_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// ---------------------------------------------------------------------------
// store_unit_pkg
// Shared types and constants for the store (memory-write) path.
//   store_state_t : control states of store_unit
//   FUNCT3__*     : store-type encodings carried in funct3
// ---------------------------------------------------------------------------
package store_unit_pkg;

    typedef enum logic [2:0] {
        STORE_STATE__IDLE,
        STORE_STATE__READ,
        STORE_STATE__WAIT,
        STORE_STATE__WRITE,
        STORE_STATE__DONE
    } store_state_t;

    localparam logic [2:0] FUNCT3__SB = 3'b000;
    localparam logic [2:0] FUNCT3__SH = 3'b001;
    localparam logic [2:0] FUNCT3__SW = 3'b010;

endpackage

// File: rtl/store_unit_merge.sv
// ---------------------------------------------------------------------------
// store_merge
// Combinational merge of store data into the previously read memory word.
// Ports:
//   i_old_word [XLEN] : word read back from memory
//   i_wdata    [XLEN] : store data (rs2)
//   i_funct3   [3]    : store type (sb/sh/sw)
//   i_offset   [2]    : byte offset addr[1:0]
//   o_merged   [XLEN] : word to write back
// sh only looks at i_offset[1]; sw ignores the offset entirely.
// Unknown funct3 passes the old word through.
// ---------------------------------------------------------------------------
module store_merge
    import store_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_old_word,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    output logic [XLEN-1:0] o_merged
);

    always_comb begin
        o_merged = i_old_word;
        unique case (i_funct3)
            FUNCT3__SB: o_merged[{i_offset, 3'b000} +: 8]        = i_wdata[7:0];
            FUNCT3__SH: o_merged[{i_offset[1], 4'b0000} +: 16]   = i_wdata[15:0];
            FUNCT3__SW: o_merged = i_wdata;
            default:    o_merged = i_old_word;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// ---------------------------------------------------------------------------
// store_unit
// Executes sb/sh/sw against a word-wide memory that has only a whole-word
// write enable. Sub-word stores do read-modify-write; sw writes directly.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, accepted only in IDLE
//   funct3       : store type (000 sb, 001 sh, 010 sw, others invalid)
//   addr, wdata  : byte address and store data
//   mem_rdata    : memory read data (RD_LATENCY 0 = comb, 1 = registered)
//   mem_addr     : word-aligned memory address (0 outside READ/WAIT/WRITE)
//   mem_wdata    : merged write word (driven in WRITE, 0 otherwise)
//   mem_we       : one-cycle write pulse
//   busy, done   : busy in READ/WAIT/WRITE, done pulses in DONE
//   misaligned   : valid with done
// Build option: define STORE_MISALIGN_TRAP_EN to trap misaligned sh/sw
// (straight to DONE with misaligned=1, no memory access). Without it,
// misaligned is 0 and sh/sw drop the low address bits.
// ---------------------------------------------------------------------------
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic            busy,
    output logic            done,
    output logic            misaligned
);

    store_state_t    r_state;
    store_state_t    w_state_next;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_old;
    logic [XLEN-1:0] w_merged;
    logic            w_accept;
    logic            w_capture;
    logic            w_req_misaligned;

    assign w_accept  = (r_state == STORE_STATE__IDLE) && start;
    // Old word is sampled on the last cycle the read address is held.
    assign w_capture = ((r_state == STORE_STATE__READ) && (RD_LATENCY == 0)) ||
                       (r_state == STORE_STATE__WAIT);

`ifdef STORE_MISALIGN_TRAP_EN
    logic r_misaligned;

    assign w_req_misaligned = ((funct3 == FUNCT3__SH) && addr[0]) ||
                              ((funct3 == FUNCT3__SW) && (addr[1:0] != 2'b00));
    assign misaligned       = (r_state == STORE_STATE__DONE) && r_misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (w_accept) begin
            r_misaligned <= w_req_misaligned;
        end
    end
`else
    assign w_req_misaligned = 1'b0;
    assign misaligned       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= STORE_STATE__IDLE;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_old    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
            end
            if (w_capture) begin
                r_old <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            STORE_STATE__IDLE: begin
                if (start) begin
                    if (w_req_misaligned) begin
                        w_state_next = STORE_STATE__DONE;
                    end else begin
                        unique case (funct3)
                            FUNCT3__SW:             w_state_next = STORE_STATE__WRITE;
                            FUNCT3__SB, FUNCT3__SH: w_state_next = STORE_STATE__READ;
                            default:                w_state_next = STORE_STATE__DONE;
                        endcase
                    end
                end
            end
            STORE_STATE__READ:  w_state_next = (RD_LATENCY == 0) ? STORE_STATE__WRITE
                                                                 : STORE_STATE__WAIT;
            STORE_STATE__WAIT:  w_state_next = STORE_STATE__WRITE;
            STORE_STATE__WRITE: w_state_next = STORE_STATE__DONE;
            STORE_STATE__DONE:  w_state_next = STORE_STATE__IDLE;
            default:            w_state_next = STORE_STATE__IDLE;
        endcase
    end

    store_merge #(
        .XLEN (XLEN)
    ) u_merge (
        .i_old_word (r_old),
        .i_wdata    (r_wdata),
        .i_funct3   (r_funct3),
        .i_offset   (r_addr[1:0]),
        .o_merged   (w_merged)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            STORE_STATE__READ, STORE_STATE__WAIT: begin
                mem_addr = {r_addr[XLEN-1:2], 2'b00};
                busy     = 1'b1;
            end
            STORE_STATE__WRITE: begin
                mem_addr  = {r_addr[XLEN-1:2], 2'b00};
                mem_wdata = w_merged;
                mem_we    = 1'b1;
                busy      = 1'b1;
            end
            STORE_STATE__DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
